// File: rtl/sdm_ctrl_pkg.sv
// Shared types and widths for the SDM stream controller.
package sdm_ctrl_pkg;
  localparam int AUDIO_W = 16;
  localparam int UCNT_W  = 8;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;
endpackage

// File: rtl/sdm_sample_buf.sv
// Two-entry per-channel sample FIFO; dout always shows the oldest entry.
module sdm_sample_buf
  import sdm_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [AUDIO_W-1:0] din,
  output logic [1:0]         count,
  output logic [AUDIO_W-1:0] dout
);
  logic [1:0][AUDIO_W-1:0] mem;
  logic                    wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  assign do_push = push & (count != 2'd2);
  assign do_pop  = pop & (count != 2'd0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage needs no reset: entries are only read once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/sdm_stream_ctrl.sv
// Sample-rate scheduler: buffers PCM per channel and strobes the SDM
// modulators/demodulators, holding one sample per channel for OSR strobes.
module sdm_stream_ctrl
  import sdm_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int OSR     = 64,
  parameter int NCH     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic                          clr_status,
  input  logic [NCH-1:0]                s_valid,
  output logic [NCH-1:0]                s_ready,
  input  logic [NCH-1:0][AUDIO_W-1:0]   s_data,
  output logic                          dac_valid,
  output logic [NCH-1:0][AUDIO_W-1:0]   dac_data,
  output logic                          adc_valid,
  output logic                          busy,
  output logic [NCH-1:0]                underrun,
  output logic [NCH-1:0][UCNT_W-1:0]    underrun_cnt
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int OW = $clog2(OSR);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [OW-1:0] OSR_MAX = OW'(OSR - 1);

  state_t                      state, state_nxt;
  logic [DW-1:0]               div_cnt, div_nxt;
  logic [OW-1:0]               osr_cnt, osr_nxt;
  logic                        start_pop, bnd_pop, zero_data, boundary, strobe_nxt;
  logic [NCH-1:0]              avail, pop;
  logic [NCH-1:0][1:0]         count;
  logic [NCH-1:0][AUDIO_W-1:0] dout;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    sdm_sample_buf u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (s_valid[g] & s_ready[g]),
      .pop   (pop[g]),
      .din   (s_data[g]),
      .count (count[g]),
      .dout  (dout[g])
    );
    assign avail[g]   = (count[g] != 2'd0);
    assign s_ready[g] = (count[g] != 2'd2) & rst_n;
    assign pop[g]     = start_pop | (bnd_pop & avail[g]);
  end

  // dac_valid is the registered strobe, so it marks the current strobe cycle.
  assign boundary = dac_valid & (osr_cnt == OSR_MAX);

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    osr_nxt   = osr_cnt;
    start_pop = 1'b0;
    bnd_pop   = 1'b0;
    zero_data = 1'b0;
    case (state)
      IDLE: begin
        div_nxt = '0;
        osr_nxt = '0;
        if (run) state_nxt = PRIME;
      end
      PRIME: begin
        div_nxt = '0;
        osr_nxt = '0;
        if (!run) state_nxt = IDLE;
        else if (&avail) begin
          state_nxt = RUN;
          start_pop = 1'b1;
        end
      end
      RUN, DRAIN: begin
        div_nxt = (div_cnt == DIV_MAX) ? '0 : div_cnt + DW'(1);
        if (dac_valid) osr_nxt = (osr_cnt == OSR_MAX) ? '0 : osr_cnt + OW'(1);
        if (state == RUN) begin
          bnd_pop = boundary;
          if (!run) state_nxt = DRAIN;
        end else if (boundary) begin
          state_nxt = IDLE;
          zero_data = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    strobe_nxt = ((state_nxt == RUN) || (state_nxt == DRAIN)) && (div_nxt == DIV_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      div_cnt      <= '0;
      osr_cnt      <= '0;
      dac_valid    <= 1'b0;
      adc_valid    <= 1'b0;
      busy         <= 1'b0;
      dac_data     <= '0;
      underrun     <= '0;
      underrun_cnt <= '0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      osr_cnt   <= osr_nxt;
      dac_valid <= strobe_nxt;
      adc_valid <= strobe_nxt;
      busy      <= (state_nxt != IDLE);
      for (int c = 0; c < NCH; c++) begin
        if (zero_data) dac_data[c] <= '0;
        else if (start_pop | bnd_pop) dac_data[c] <= avail[c] ? dout[c] : '0;
        // An empty channel at a boundary is an underrun; a clear in that cycle wins.
        if (clr_status) begin
          underrun[c]     <= 1'b0;
          underrun_cnt[c] <= '0;
        end else if (bnd_pop && !avail[c]) begin
          underrun[c] <= 1'b1;
          if (underrun_cnt[c] != '1) underrun_cnt[c] <= underrun_cnt[c] + UCNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_sdm_stream_ctrl.sv
// Bench for sdm_stream_ctrl with CLK_DIV=4, OSR=8, NCH=2.
module tb_sdm_stream_ctrl;
  import sdm_ctrl_pkg::*;
  localparam int CLK_DIV = 4;
  localparam int OSR     = 8;
  localparam int NCH     = 2;

  logic                     clk = 1'b0;
  logic                     rst_n, run, clr_status;
  logic [NCH-1:0]           s_valid, s_ready;
  logic [NCH-1:0][15:0]     s_data, dac_data;
  logic                     dac_valid, adc_valid, busy;
  logic [NCH-1:0]           underrun;
  logic [NCH-1:0][7:0]      underrun_cnt;

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;
  vec_t        tbl[5];
  logic [31:0] exp_q[$];

  int total = 0, bad = 0, cyc = 0;
  int gap = 0, s_gap = 0, str_cnt = 0;
  int n_m, t0, t_r;
  logic mon_en = 1'b0, str_en = 1'b0, first_ld = 1'b1, s_seen = 1'b0;
  logic [31:0] prev_dac = '0;

  localparam logic [31:0] A1 = 32'h1111_0111;
  localparam logic [31:0] A2 = 32'h2222_0222;
  localparam logic [31:0] A3 = 32'h3333_0333;
  localparam logic [31:0] B0 = 32'h0000_0B0B;
  localparam logic [31:0] C0 = 32'h4444_0444;

  sdm_stream_ctrl #(.CLK_DIV(CLK_DIV), .OSR(OSR), .NCH(NCH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .clr_status   (clr_status),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .dac_valid    (dac_valid),
    .dac_data     (dac_data),
    .adc_valid    (adc_valid),
    .busy         (busy),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  // Scoreboard and strobe-cadence monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    gap++;
    if (mon_en && dac_data !== prev_dac) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got %h want no load", dac_data);
      end else begin
        chk("sb_data", dac_data, exp_q.pop_front());
        if (!first_ld) chk("sb_hold", gap, 32);
        first_ld = 1'b0;
      end
      gap = 0;
    end
    prev_dac = dac_data;
    if (str_en) begin
      s_gap++;
      chk("adc_eq_dac", {31'd0, adc_valid}, {31'd0, dac_valid});
      if (dac_valid) begin
        if (s_seen) chk("strobe_gap", s_gap, 4);
        s_seen = 1'b1;
        s_gap  = 0;
      end
    end
    if (dac_valid) str_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'h8000_1234, 32'h8000_1234};
    tbl[1] = '{32'hFFFF_0001, 32'hFFFF_0001};
    tbl[2] = '{32'h8001_7FFF, 32'h8001_7FFF};
    tbl[3] = '{32'h5A5A_A5A5, 32'h5A5A_A5A5};
    tbl[4] = '{32'hF0F0_0F0F, 32'hF0F0_0F0F};

    rst_n = 1'b0; run = 1'b0; clr_status = 1'b0; s_valid = '0; s_data = '0;
    repeat (2) tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dac_valid", dac_valid, 0);
    chk("rst_adc_valid", adc_valid, 0);
    chk("rst_dac_data", dac_data, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ucnt", underrun_cnt, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_s_ready", s_ready, 2'b11);

    // Basic streaming through the vector table.
    str_en = 1'b1; mon_en = 1'b1;
    s_data = tbl[0].din; s_valid = 2'b11; exp_q.push_back(tbl[0].exp); run = 1'b1;
    tick();
    s_valid = '0;
    chk("prime_busy", busy, 1);
    fork
      begin
        for (int i = 1; i < 5; i++) begin
          int n;
          n = 0;
          while (s_ready !== 2'b11 && n < 200) begin tick(); n++; end
          chk("feed_ready", s_ready, 2'b11);
          s_data = tbl[i].din; s_valid = 2'b11; exp_q.push_back(tbl[i].exp);
          tick();
          s_valid = '0;
        end
      end
      begin
        int n;
        n = 0;
        while (dac_data == '0 && n < 20) begin tick(); n++; end
        chk("first_load", dac_data, tbl[0].exp);
        n = 0;
        while (!dac_valid && n < 20) begin tick(); n++; end
        chk("first_strobe_lat", n, 3);
      end
    join
    n_m = 0;
    while (exp_q.size() != 0 && n_m < 400) begin tick(); n_m++; end
    chk("sb_drained", exp_q.size(), 0);
    mon_en = 1'b0; run = 1'b0;
    n_m = 0;
    while (busy && n_m < 100) begin tick(); n_m++; end
    chk("stop_idle", busy, 0);
    chk("stop_data", dac_data, 0);
    chk("stop_underrun", underrun, 0);
    chk("stop_empty", s_ready, 2'b11);
    str_en = 1'b0;

    // Backpressure with run low, then start.
    s_data = A1; s_valid = 2'b11;
    tick();
    chk("bp_one", s_ready, 2'b11);
    s_data = A2;
    tick();
    chk("bp_full", s_ready, 2'b00);
    s_data = A3;
    repeat (3) tick();
    chk("bp_hold", s_ready, 2'b00);
    run = 1'b1;
    repeat (2) tick();
    t0 = cyc; str_cnt = 0;
    chk("bp_reready", s_ready, 2'b11);
    chk("bp_load", dac_data, A1);
    tick();
    chk("bp_refull", s_ready, 2'b00);
    s_valid = '0;

    // Stop mid-sample: strobes run to the boundary, no pop.
    repeat (3) tick();
    run = 1'b0;
    tick();
    chk("drain_busy", busy, 1);
    chk("drain_hold", dac_data, A1);
    n_m = 0;
    while (busy && n_m < 100) begin tick(); n_m++; end
    chk("drain_len", cyc - t0, 32);
    chk("drain_strobes", str_cnt, 8);
    chk("drain_data", dac_data, 0);
    chk("drain_nopop", s_ready, 2'b00);
    chk("drain_underrun", underrun, 0);

    // Restart, then starve channel 1.
    run = 1'b1;
    repeat (2) tick();
    t_r = cyc;
    chk("restart_load", dac_data, A2);
    s_data = B0; s_valid = 2'b01;
    tick();
    s_valid = '0;
    wait_until(t_r + 32);
    chk("b1_data", dac_data, A3);
    chk("b1_underrun", underrun, 0);
    wait_until(t_r + 64);
    chk("b2_data", dac_data, B0);
    chk("b2_underrun", underrun, 2'b10);
    chk("b2_ucnt", underrun_cnt, 16'h0100);
    wait_until(t_r + 96);
    chk("b3_data", dac_data, 0);
    chk("b3_underrun", underrun, 2'b11);
    chk("b3_ucnt", underrun_cnt, 16'h0201);
    wait_until(t_r + 127);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("clrwin_underrun", underrun, 0);
    chk("clrwin_ucnt", underrun_cnt, 0);
    wait_until(t_r + 160);
    chk("b5_ucnt", underrun_cnt, 16'h0101);
    wait_until(t_r + 160 + 32 * 300);
    chk("sat_ucnt", underrun_cnt, 16'hFFFF);
    chk("sat_underrun", underrun, 2'b11);
    wait_until(t_r + 160 + 32 * 300 + 5);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("clr_ucnt", underrun_cnt, 0);
    chk("clr_underrun", underrun, 0);

    // Fill buffers while running, then reset mid-stream.
    s_data = C0; s_valid = 2'b11;
    repeat (3) tick();
    chk("fill_full", s_ready, 2'b00);
    rst_n = 1'b0; run = 1'b0; s_valid = '0;
    tick();
    chk("mrst_busy", busy, 0);
    chk("mrst_dac_valid", dac_valid, 0);
    chk("mrst_adc_valid", adc_valid, 0);
    chk("mrst_data", dac_data, 0);
    chk("mrst_ucnt", underrun_cnt, 0);
    chk("mrst_underrun", underrun, 0);
    chk("mrst_s_ready", s_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("mrst_empty", s_ready, 2'b11);
    str_cnt = 0;
    repeat (40) tick();
    chk("mrst_no_strobe", str_cnt, 0);
    chk("mrst_idle", busy, 0);
    run = 1'b1;
    repeat (40) tick();
    chk("mrst_prime_wait", busy, 1);
    chk("mrst_prime_data", dac_data, 0);
    chk("mrst_prime_strobe", str_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
